// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Valid/ready on both sides; result held until the consumer takes it.
module seq_divider #(
  parameter int BITWIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] dividend,
  input  logic [BITWIDTH-1:0] divisor,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITWIDTH-1:0] quotient,
  output logic [BITWIDTH-1:0] remainder,
  output logic                div_by_zero
);

  localparam int W  = BITWIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [W-1:0]  dvd;
  logic [W-1:0]  dsr;
  logic [CW-1:0] cnt;
  logic          last;
  logic [W-1:0]  acc;
  logic [W:0]    trial;
  logic          qbit;

  assign last = (cnt == CW'(W - 1));

  // One restoring step; the first step starts from a zero partial
  // remainder so the visible remainder is untouched until RUN.
  always_comb begin
    acc   = (cnt == '0) ? '0 : remainder;
    trial = {acc, dvd[W-1]};
    qbit  = (trial >= {1'b0, dsr});
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture and the shift/subtract datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd         <= '0;
      dsr         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd         <= dividend;
            dsr         <= divisor;
            cnt         <= '0;
            div_by_zero <= (divisor == '0);
          end
        end
        RUN: begin
          dvd      <= {dvd[W-2:0], 1'b0};
          quotient <= {quotient[W-2:0], qbit};
          if (qbit) remainder <= W'(trial - {1'b0, dsr});
          else      remainder <= trial[W-1:0];
          if (!last) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider at BITWIDTH=8.
// Table vectors plus backpressure, reset and back-to-back sequences.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  seq_divider #(.BITWIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .dividend(dividend),
    .divisor(divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for in_ready, present a pair for one accept edge
  // and then scramble the operand inputs.
  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("in_ready_before_issue", in_ready, 1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    dividend = ~a;
    divisor  = b + 8'd1;
  endtask

  // Count edges after the accept edge until out_valid, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int lat;
    issue(v.a, v.b);
    chk({nm, "_busy"}, in_ready, 0);
    wait_done(lat);
    chk({nm, "_latency"}, lat, 8);
    chk({nm, "_q"}, quotient, v.q);
    chk({nm, "_r"}, remainder, v.r);
    chk({nm, "_dbz"}, div_by_zero, v.z);
    tick();
    chk({nm, "_ovalid_drop"}, out_valid, 0);
    chk({nm, "_iready_back"}, in_ready, 1);
  endtask

  initial begin
    int lat;
    int t_prev;
    int n;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] eq;
    logic [7:0] er;

    vecs[0] = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0};
    vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
    vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
    vecs[3] = '{8'd0,   8'd3,   8'd0,   8'd0,   1'b0};
    vecs[4] = '{8'd77,  8'd0,   8'd255, 8'd77,  1'b1};
    vecs[5] = '{8'd13,  8'd13,  8'd1,   8'd0,   1'b0};
    vecs[6] = '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0};
    vecs[7] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
    vecs[8] = '{8'd128, 8'd2,   8'd64,  8'd0,   1'b0};
    vecs[9] = '{8'd0,   8'd0,   8'd255, 8'd0,   1'b1};

    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result must hold, busy inputs ignored.
    out_ready = 1'b0;
    issue(8'd100, 8'd10);
    wait_done(lat);
    chk("bp_latency", lat, 8);
    in_valid = 1'b1;
    dividend = 8'd9;
    divisor  = 8'd4;
    for (int i = 0; i < 20; i++) begin
      chk("bp_ovalid", out_valid, 1);
      chk("bp_q", quotient, 10);
      chk("bp_r", remainder, 0);
      chk("bp_iready", in_ready, 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_ovalid", out_valid, 0);
    chk("bp_release_iready", in_ready, 1);
    chk("bp_q_kept", quotient, 10);

    // Reset in the middle of 250/3.
    issue(8'd250, 8'd3);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_iready", in_ready, 1);
    chk("mid_rst_ovalid", out_valid, 0);
    chk("mid_rst_q", quotient, 0);
    chk("mid_rst_r", remainder, 0);
    chk("mid_rst_dbz", div_by_zero, 0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("post_rst_ovalid", out_valid, 0);
    run_vec('{8'd9, 8'd2, 8'd4, 8'd1, 1'b0}, "after_rst");

    // Back-to-back with in_valid held high.
    ra = 8'($urandom_range(0, 255));
    rb = 8'($urandom_range(1, 255));
    dividend = ra;
    divisor  = rb;
    in_valid = 1'b1;
    t_prev = -1;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      while (!in_ready && n < 50) begin
        tick();
        n++;
      end
      tick();
      if (t_prev >= 0) chk("b2b_period", cyc - t_prev, 10);
      t_prev = cyc;
      if (rb == 8'd0) begin
        eq = 8'hFF;
        er = ra;
      end else begin
        eq = ra / rb;
        er = ra % rb;
      end
      dividend = 8'($urandom_range(0, 255));
      divisor  = 8'($urandom_range(0, 255));
      wait_done(lat);
      chk("b2b_latency", lat, 8);
      chk("b2b_q", quotient, eq);
      chk("b2b_r", remainder, er);
      chk("b2b_dbz", div_by_zero, (rb == 8'd0) ? 1 : 0);
      ra = 8'($urandom_range(0, 255));
      rb = (i == 3) ? 8'd0 : 8'($urandom_range(1, 255));
      dividend = ra;
      divisor  = rb;
    end
    in_valid = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
